// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and byte-level helpers used by the round
// controller and the round datapath.
package aes_pkg;

   localparam int NK = 4;
   localparam int NR = 10;
   localparam logic [3:0] LAST_ROUND = 4'(NR);

   typedef logic [0:127] aes_state_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_HOLD  = 2'd2
   } aes_fsm_t;

   // Forward S-box, byte n at bits [8n +: 8]
   localparam logic [0:2047] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] r;
      case (rnd)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped in the final round), then AddRoundKey.
module aes_round
   import aes_pkg::*;
(
   input  aes_state_t state_in,
   input  aes_state_t round_key,
   input  logic       skip_mix,
   output aes_state_t state_out
);

   aes_state_t sub_s;
   aes_state_t shift_s;
   aes_state_t mix_s;
   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      sub_s   = '0;
      shift_s = '0;
      mix_s   = '0;
      a0      = '0;
      a1      = '0;
      a2      = '0;
      a3      = '0;
      for (int i = 0; i < 16; i++) begin
         sub_s[8*i +: 8] = sbox(state_in[8*i +: 8]);
      end
      // Byte index is row + 4*column; row r rotates left by r columns
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_s[8*(r + 4*c) +: 8] = sub_s[8*(r + 4*((c + r) % 4)) +: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0 = shift_s[32*c      +: 8];
         a1 = shift_s[32*c + 8  +: 8];
         a2 = shift_s[32*c + 16 +: 8];
         a3 = shift_s[32*c + 24 +: 8];
         mix_s[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mix_s[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mix_s[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mix_s[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   end

   assign state_out = (skip_mix ? shift_s : mix_s) ^ round_key;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock through a
// shared round datapath, with the key schedule expanded on the fly.
module aes_round_ctrl
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] plaintext,
   input  logic [0:127] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] ciphertext,
   output logic [3:0]   round,
   output aes_fsm_t     state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_ready depends only on FSM state (and reset), out_valid only on FSM
   // state, so neither ready nor valid combinationally follows its partner.

   aes_fsm_t   fsm_q, fsm_d;
   aes_state_t state_q, state_d;
   aes_state_t key_q, key_d;
   logic [3:0] round_q, round_d;
   aes_state_t next_key;
   aes_state_t round_out;

   logic [0:31] w0, w1, w2, w3, t, n0, n1, n2, n3;

   always_comb begin
      w0 = key_q[0:31];
      w1 = key_q[32:63];
      w2 = key_q[64:95];
      w3 = key_q[96:127];
      // SubWord(RotWord(w3)) xor Rcon in the leading byte
      t  = {sbox(w3[8:15]), sbox(w3[16:23]), sbox(w3[24:31]), sbox(w3[0:7])}
           ^ {rcon(round_q), 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   aes_round u_round (
      .state_in  (state_q),
      .round_key (next_key),
      .skip_mix  (round_q == LAST_ROUND),
      .state_out (round_out)
   );

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      case (fsm_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = plaintext ^ key;
               key_d   = key;
               round_d = 4'd1;
               fsm_d   = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_d = round_out;
            key_d   = next_key;
            if (round_q == LAST_ROUND) fsm_d = ST_HOLD;
            else                       round_d = round_q + 4'd1;
         end
         ST_HOLD: begin
            if (out_ready) begin
               fsm_d   = ST_IDLE;
               round_d = 4'd0;
            end
         end
         default: begin
            fsm_d   = ST_IDLE;
            round_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         key_q   <= '0;
         round_q <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
      end
   end

   assign in_ready   = rst_n && (fsm_q == ST_IDLE);
   assign out_valid  = (fsm_q == ST_HOLD);
   assign ciphertext = state_q;
   assign round      = round_q;
   assign state_dbg  = fsm_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed FIPS-197 vectors for aes_round_ctrl: latency, backpressure,
// back-to-back throughput, mid-round reset and input changes while busy.
module tb_aes_round_ctrl;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [0:127] plaintext;
   logic [0:127] key;
   logic         out_valid;
   logic         out_ready;
   logic [0:127] ciphertext;
   logic [3:0]   round;
   aes_fsm_t     state_dbg;

   int n_vec = 0;
   int n_err = 0;
   logic [127:0] exp_q[$];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_K1   = 128'ha0fafe1788542cb123a339392a6c7605;

   aes_round_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .round      (round),
      .state_dbg  (state_dbg)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // driver: one full block with out_ready high, optional input churn
   task automatic run_vec(input logic [127:0] k, input logic [127:0] pt,
                          input logic [127:0] ct, input bit toggle,
                          input bit chk_k1, input logic [127:0] k1);
      int lat;
      check("ready_before", in_ready, 1'b1);
      key       = k;
      plaintext = pt;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("round_after_accept", round, 4'd1);
      check("ready_low_busy", in_ready, 1'b0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (toggle) begin
            plaintext = rand128();
            key       = rand128();
            in_valid  = 1'($urandom_range(0, 1));
         end
         tick();
         lat++;
         if (chk_k1 && lat == 1) check("key_round1", dut.key_q, k1);
      end
      in_valid = 1'b0;
      check("latency", lat, 10);
      check("ciphertext", ciphertext, ct);
      check("no_ready_with_valid", in_ready, 1'b0);
      tick();
      check("hold_one_cycle", out_valid, 1'b0);
      check("ready_after_hold", in_ready, 1'b1);
      check("round_idle", round, 4'd0);
   endtask

   initial begin
      int lat;
      int cyc;
      int last_acc;
      int idx;
      int results;
      bit acc;
      logic [127:0] vk[4];
      logic [127:0] vp[4];
      logic [127:0] vc[4];
      logic [127:0] exp_ct;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      plaintext = '0;
      key       = '0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_round", round, 4'd0);
      check("rst_state", ciphertext, 128'h0);
      rst_n = 1'b1;
      tick();
      check("idle_ready", in_ready, 1'b1);

      run_vec(C1_KEY, C1_PT, C1_CT, 1'b0, 1'b0, '0);
      run_vec(B_KEY, B_PT, B_CT, 1'b0, 1'b1, B_K1);
      run_vec(C1_KEY, C1_PT, C1_CT, 1'b1, 1'b0, '0);
      run_vec(B_KEY, B_PT, B_CT, 1'b1, 1'b1, B_K1);

      // backpressure: keep a competing request pending throughout HOLD
      key       = C1_KEY;
      plaintext = C1_PT;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      key       = B_KEY;
      plaintext = B_PT;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("bp_latency", lat, 10);
      for (int i = 0; i < 20; i++) begin
         check("bp_ct_stable", ciphertext, C1_CT);
         check("bp_ready_low", in_ready, 1'b0);
         check("bp_valid_held", out_valid, 1'b1);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", out_valid, 1'b0);
      check("bp_release_ready", in_ready, 1'b1);
      check("bp_not_accepted", round, 4'd0);

      // back-to-back with in_valid held high, scoreboard on results
      vk[0] = C1_KEY; vp[0] = C1_PT; vc[0] = C1_CT;
      vk[1] = B_KEY;  vp[1] = B_PT;  vc[1] = B_CT;
      vk[2] = C1_KEY; vp[2] = C1_PT; vc[2] = C1_CT;
      vk[3] = B_KEY;  vp[3] = B_PT;  vc[3] = B_CT;
      idx       = 0;
      results   = 0;
      cyc       = 0;
      last_acc  = -1;
      key       = vk[0];
      plaintext = vp[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (results < 4 && cyc < 100) begin
         acc = in_valid && in_ready;
         tick();
         cyc++;
         if (acc) begin
            exp_q.push_back(vc[idx]);
            if (last_acc >= 0) check("b2b_interval", cyc - last_acc, 12);
            last_acc = cyc;
            idx++;
            if (idx == 4) begin
               in_valid = 1'b0;
            end else begin
               key       = vk[idx];
               plaintext = vp[idx];
            end
         end
         if (out_valid) begin
            check("b2b_exclusive", in_ready, 1'b0);
            if (exp_q.size() == 0) begin
               check("b2b_unexpected_result", 1'b1, 1'b0);
            end else begin
               exp_ct = exp_q.pop_front();
               check("b2b_ct", ciphertext, exp_ct);
            end
            results++;
         end
      end
      check("b2b_result_count", results, 4);
      in_valid = 1'b0;
      tick();
      tick();

      // reset in the middle of round 5, then a clean run
      check("pre_abort_ready", in_ready, 1'b1);
      key       = C1_KEY;
      plaintext = C1_PT;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("abort_at_round5", round, 4'd5);
      rst_n = 1'b0;
      #1;
      check("abort_ready_in_reset", in_ready, 1'b0);
      tick();
      check("abort_round", round, 4'd0);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_state_clr", ciphertext, 128'h0);
      check("abort_key_clr", dut.key_q, 128'h0);
      rst_n = 1'b1;
      tick();
      run_vec(C1_KEY, C1_PT, C1_CT, 1'b0, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption controller that sequences one cipher round per clock through a shared combinational round datapath. It accepts a 128-bit plaintext and key over a valid/ready handshake and performs the initial AddRoundKey. It then runs rounds 1–10 while expanding the key on the fly, and presents the ciphertext on a held valid/ready output. It sits between the bus-facing wrapper and the round primitives (SubBytes, ShiftRows, MixColumns, AddRoundKey).

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10 are package constants).
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `in_valid` in 1 — plaintext/key present.
- `in_ready` out 1 — controller can accept; high only in IDLE.
- `plaintext` in [0:127] — byte 0 = bits [0:7], column-major per FIPS-197.
- `key` in [0:127] — cipher key, same byte ordering.
- `out_valid` out 1 — ciphertext valid; held until accepted.
- `out_ready` in 1 — consumer accepts ciphertext.
- `ciphertext` out [0:127] — result, same byte ordering.
- `round` out 4 — current round number, for debug (0 in IDLE).

## Operation
- FSM states: IDLE, ROUND, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: `state_q` ← plaintext ^ key; `key_q` ← key; `round`←1; go to ROUND.
- ROUND, each cycle:
  - `state_q` ← aes_round(`state_q`, next_key, skip_mix = (`round`==10)).
  - `key_q` ← next_key, where next_key = key_expand_step(`key_q`, rcon[`round`]).
  - rcon: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
  - `round`==10 → go to HOLD; else `round`←`round`+1.
- HOLD:
  - `out_valid`=1; `ciphertext`=`state_q`, stable until accepted.
  - On `out_ready`: go to IDLE, `round`←0.
- Key expansion per round:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - All XOR; no carries; widths fixed at 32 bits per word.
- Inputs are ignored outside IDLE. `plaintext`/`key` may change after acceptance.
- Reset (any state, including mid-round):
  - Next edge → IDLE; `out_valid`=0, `round`=0, `state_q`/`key_q`=0.
  - `in_ready`=0 while `rst_n` low; the in-flight block is discarded.
- `ciphertext` is driven from `state_q` at all times; it is meaningful only when `out_valid`=1.

## Timing
- Acceptance at edge E0 (`in_valid` & `in_ready`).
- Rounds 1..10 complete at edges E1..E10.
- `out_valid` rises after E10: latency 10 cycles from acceptance to first valid cycle.
- If `out_ready` is already high, HOLD lasts 1 cycle and `in_ready` returns after E11.
- Minimum initiation interval: 12 cycles.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- `in_ready` and `out_valid` are never high in the same cycle.
- Critical path: S-box + ShiftRows + MixColumns + XOR, all within one cycle. SubWord S-boxes run in parallel.

## Structure
- Package `aes_pkg` holds:
  - NR=10.
  - Rcon table.
  - S-box function.
  - `aes_state_t` (logic [0:127]).
  - FSM state enum.
- Sub-module `aes_round`: combinational SubBytes → ShiftRows → optional MixColumns → AddRoundKey, with a `skip_mix` input. It reuses the team's round primitives.
- The key expansion step is kept inline in the controller (about 20 lines).

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a. `out_valid` first high exactly 10 cycles after acceptance.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. After round 1, `key_q`=a0fafe1788542cb123a339392a6c7605.
- Backpressure: hold `out_ready`=0 for 20 cycles. `ciphertext` stays stable, `in_ready` stays 0, and a new `in_valid` is not accepted. Raise `out_ready` → IDLE on the next edge.
- Back-to-back: drive `in_valid` continuously with both vectors. Each result is correct, and acceptances are exactly 12 cycles apart with `out_ready`=1.
- Reset at round 5 → next cycle `round`=0 and `out_valid`=0. Then a fresh C.1 run produces the correct ct with no residue from the aborted block.
- Input change during ROUND: toggle `plaintext`/`key` every cycle after acceptance → ct unaffected.
